// File: rtl/updown_mod_counter.sv
// Up/down counter over a programmable range 0..limit with load, enable,
// wrap-or-saturate behaviour, a one-cycle boundary pulse and a sticky flag.
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_VALUE = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  always_comb begin
    out_d    = out_q;
    boundary = 1'b0;
    if (load) begin
      out_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (up) begin
        // out above limit (limit lowered mid-count) is treated like out == limit
        if (out_q < limit) begin
          out_d = out_q + 1'b1;
        end else begin
          boundary = 1'b1;
          out_d    = SATURATE ? limit : '0;
        end
      end else begin
        if (out_q > limit) begin
          out_d = limit;
        end else if (out_q != '0) begin
          out_d = out_q - 1'b1;
        end else begin
          boundary = 1'b1;
          out_d    = SATURATE ? '0 : limit;
        end
      end
    end
  end

  always_comb begin
    wrap_d = boundary;
    ovf_d  = ovf_q;
    if (boundary) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= RST_VALUE;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Three counter configurations driven by shared stimulus, each checked
// against an arithmetic reference model of the counting rules.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr_ovf;
  logic [7:0] load_val, limit;

  logic [7:0] out_w8, out_s8;
  logic [2:0] out_w3;
  logic       wrap_w8, wrap_s8, wrap_w3;
  logic       ovf_w8, ovf_s8, ovf_w3;

  int nassert = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(0)) u_w8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .clr_ovf(clr_ovf),
    .out(out_w8), .wrap(wrap_w8), .ovf(ovf_w8));

  updown_mod_counter #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL('h1A5)) u_s8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .clr_ovf(clr_ovf),
    .out(out_s8), .wrap(wrap_s8), .ovf(ovf_s8));

  updown_mod_counter #(.WIDTH(3), .SATURATE(1'b0), .RESET_VAL(0)) u_w3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[2:0]), .limit(limit[2:0]), .clr_ovf(clr_ovf),
    .out(out_w3), .wrap(wrap_w3), .ovf(ovf_w3));

  // Reference model: per-instance width mask, mode and reset value.
  int unsigned m_mask[3] = '{32'hFF, 32'hFF, 32'h7};
  bit          m_sat[3]  = '{1'b0, 1'b1, 1'b0};
  int unsigned m_rst[3]  = '{0, 32'hA5, 0};
  int unsigned m_out[3];
  bit          m_wrap[3];
  bit          m_ovf[3];

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int unsigned lim, lv, o;
      bit          ev;
      lim = limit & m_mask[i];
      lv  = load_val & m_mask[i];
      o   = m_out[i];
      ev  = 1'b0;
      if (reset) begin
        m_out[i] = m_rst[i]; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        if (load) begin
          o = (lv < lim) ? lv : lim;
        end else if (en && up) begin
          if (o < lim) o = o + 1;
          else begin ev = 1'b1; o = m_sat[i] ? lim : 0; end
        end else if (en) begin
          if (o > lim) o = lim;
          else if (o > 0) o = o - 1;
          else begin ev = 1'b1; o = m_sat[i] ? 0 : lim; end
        end
        m_out[i]  = o & m_mask[i];
        m_wrap[i] = ev;
        if (ev) m_ovf[i] = 1'b1;
        else if (clr_ovf) m_ovf[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("w8.out", out_w8, m_out[0]);  chk("w8.wrap", wrap_w8, m_wrap[0]);
    chk("w8.ovf", ovf_w8, m_ovf[0]);
    chk("s8.out", out_s8, m_out[1]);  chk("s8.wrap", wrap_s8, m_wrap[1]);
    chk("s8.ovf", ovf_s8, m_ovf[1]);
    chk("w3.out", out_w3, m_out[2]);  chk("w3.wrap", wrap_w3, m_wrap[2]);
    chk("w3.ovf", ovf_w3, m_ovf[2]);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
    load_val = '0; limit = 8'd7;
    for (int i = 0; i < 3; i++) begin m_out[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; end
    cycle();
    chk("rst.s8_trunc", out_s8, 8'hA5);

    // Full 3-bit range behaves like a plain counter
    reset = 1'b0; en = 1'b1; up = 1'b1;
    repeat (8) cycle();
    chk("plain.w3_out", out_w3, 0);
    chk("plain.w3_wrap", wrap_w3, 1);
    cycle();
    chk("plain.w3_ovf", ovf_w3, 1);

    // Modulo-10 up, then reverse at 3
    reset = 1'b1; cycle();
    reset = 1'b0; limit = 8'd9;
    repeat (13) cycle();
    chk("mod10.at3", out_w8, 3);
    up = 1'b0;
    repeat (5) cycle();
    chk("mod10.down", out_w8, 8);

    // Saturating mode holds at both ends
    reset = 1'b1; cycle();
    reset = 1'b0; limit = 8'd5; up = 1'b1;
    repeat (8) cycle();
    chk("sat.hi_out", out_s8, 5);
    chk("sat.hi_wrap", wrap_s8, 1);
    up = 1'b0;
    repeat (8) cycle();
    chk("sat.lo_out", out_s8, 0);
    chk("sat.lo_wrap", wrap_s8, 1);

    // Reset beats load and en; load clamps and beats en
    reset = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1;
    load_val = 8'd200; limit = 8'd100;
    cycle();
    chk("rstpri.out", out_w8, 0);
    chk("rstpri.ovf", ovf_w8, 0);
    reset = 1'b0;
    cycle();
    chk("load.clamp", out_w8, 100);
    load = 1'b0;
    cycle();
    chk("load.wrap", wrap_w8, 1);
    chk("load.ovf", ovf_w8, 1);

    // Limit lowered below the count
    load = 1'b1; load_val = 8'd40; limit = 8'd50; cycle();
    load = 1'b0; limit = 8'd10; cycle();
    chk("lower.up", out_w8, 0);
    load = 1'b1; limit = 8'd50; cycle();
    load = 1'b0; en = 1'b0; clr_ovf = 1'b1; cycle();
    clr_ovf = 1'b0; en = 1'b1; up = 1'b0; limit = 8'd10; cycle();
    chk("lower.down", out_w8, 10);
    chk("lower.nowrap", wrap_w8, 0);
    chk("lower.ovf", ovf_w8, 0);

    // Degenerate range and set-beats-clear
    limit = 8'd0; up = 1'b1; cycle();
    clr_ovf = 1'b1; cycle();
    chk("l0.setwins", ovf_w8, 1);
    chk("l0.wrap", wrap_w8, 1);
    en = 1'b0; cycle();
    chk("clr.alone", ovf_w8, 0);
    clr_ovf = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 19) == 0);
      en       = ($urandom_range(0, 5) != 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 3) == 0) up = ~up;
      if ($urandom_range(0, 24) == 0)
        limit = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
